// File: rtl/therm_mem_pkg.sv
// Shared types and helpers for the thermal-sensor SRAM responder and its storage array.
package therm_mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] addr_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRespond
  } resp_state_e;

  localparam int unsigned WORD_ADDR_LSB = 2;

  typedef struct packed {
    addr_t      addr;
    logic       write;
    word_t      wdata;
    logic [3:0] strobe;
  } req_t;

  // Misaligned or beyond the last word of a depth-word array.
  function automatic logic addr_error(addr_t addr, int unsigned depth);
    return (addr[WORD_ADDR_LSB-1:0] != '0) ||
           (addr[$bits(addr_t)-1:WORD_ADDR_LSB] >= ($bits(addr_t) - WORD_ADDR_LSB)'(depth));
  endfunction

endpackage

// File: rtl/therm_sram_array.sv
// Single-port word storage: synchronous read, byte-strobed write, no reset on contents.
module therm_sram_array
  import therm_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned INDEX_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   enable,
  input  logic                   write,
  input  logic [INDEX_WIDTH-1:0] index,
  input  word_t                  wdata,
  input  logic [3:0]             strobe,
  output word_t                  rdata
);

  word_t mem [DEPTH_WORDS];
  word_t rdata_q;

  // Read register only updates on loads so it holds across stores and idle cycles.
  always_ff @(posedge clock) begin
    if (enable) begin
      if (write) begin
        for (int i = 0; i < 4; i++) begin
          if (strobe[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[index];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/therm_sram_responder.sv
// Request/response front end for the thermal SRAM: latches a request, waits WAIT_STATES cycles,
// then performs the access and pulses resp_valid.
module therm_sram_responder
  import therm_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_neg,
  input  logic        chip_enable,
  input  logic        write_enable,
  input  logic [63:0] address,
  input  logic [31:0] data_store,
  input  logic [3:0]  write_strobe,
  output logic [31:0] data_load,
  output logic        resp_valid,
  output logic        resp_error,
  output logic        busy
);

  localparam int unsigned IndexWidth = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CntInit    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Assert asynchronously, release two edges after reset_neg rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_in, cur_req;
  logic        accept, enter_resp, req_err, mem_en;
  logic        valid_q, error_q, zero_q;
  word_t       rdata;

  assign req_in = '{addr: address, write: write_enable, wdata: data_store, strobe: write_strobe};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    accept     = chip_enable && (state_q == StIdle || state_q == StRespond);
    unique case (state_q)
      StIdle, StRespond: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = CntInit;
          end else begin
            state_d    = StRespond;
            enter_resp = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d    = StRespond;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access happens on the accepting edge itself.
  assign cur_req = accept ? req_in : req_q;
  assign req_err = addr_error(cur_req.addr, DEPTH_WORDS);
  assign mem_en  = enter_resp && !req_err;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= enter_resp;
      error_q <= enter_resp && req_err;
      if (accept) req_q <= req_in;
      if (enter_resp) begin
        if (req_err)              zero_q <= 1'b1;
        else if (!cur_req.write)  zero_q <= 1'b0;
      end
    end
  end

  therm_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INDEX_WIDTH(IndexWidth)
  ) u_array (
    .clock (clock),
    .enable(mem_en),
    .write (cur_req.write),
    .index (cur_req.addr[IndexWidth+WORD_ADDR_LSB-1:WORD_ADDR_LSB]),
    .wdata (cur_req.wdata),
    .strobe(cur_req.strobe),
    .rdata (rdata)
  );

  assign data_load  = zero_q ? '0 : rdata;
  assign resp_valid = valid_q;
  assign resp_error = error_q;
  assign busy       = (state_q != StIdle);

endmodule
